// File: rtl/lms_if_pkg.sv
// Shared constants for the LMS6002D RX interface: ADC word width,
// default lock depth and the deinterleave FSM state encoding.
package lms_if_pkg;

    localparam int LMS_DW         = 12;
    localparam int LMS_OW         = 14;
    localparam int LMS_LOCK_PAIRS = 4;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_WANT_Q = 2'd1;
    localparam logic [1:0] ST_WANT_I = 2'd2;

endpackage

// File: rtl/lms_frame_mon.sv
// Framing monitor: counts consecutive good I/Q pairs to declare lock and
// keeps a saturating framing-error counter with a synchronous clear.
module lms_frame_mon
    import lms_if_pkg::*;
#(
    parameter int LOCK_PAIRS = LMS_LOCK_PAIRS,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             emit,
    input  logic             err,
    input  logic             clr_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_PAIRS);

    logic [3:0] good_cnt;

    // Lock asserts on the pair that brings the count to LOCK_TGT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_cnt <= 4'd0;
            locked   <= 1'b0;
        end else if (err) begin
            good_cnt <= 4'd0;
            locked   <= 1'b0;
        end else if (emit) begin
            if (good_cnt != LOCK_TGT)
                good_cnt <= good_cnt + 4'd1;
            if (good_cnt >= LOCK_TGT - 4'd1)
                locked <= 1'b1;
        end
    end

    // Clear takes priority over a coincident error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (clr_err)
            err_cnt <= '0;
        else if (err && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: rtl/lms_rx_iq_deinterleave.sv
// LMS6002D RX I/Q deinterleaver: pairs interleaved ADC words into aligned,
// left-justified I/Q outputs with a strobe. Optional ramp: LMS_RX_TESTPAT_EN.
module lms_rx_iq_deinterleave
    import lms_if_pkg::*;
#(
    parameter int DW         = LMS_DW,
    parameter int OW         = LMS_OW,
    parameter int LOCK_PAIRS = LMS_LOCK_PAIRS,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DW-1:0]    rx_d,
    input  logic             rx_iqsel,
    input  logic             swap_iq,
    input  logic             test_mode,
    input  logic             clr_err,
    output logic [OW-1:0]    adc_i,
    output logic [OW-1:0]    adc_q,
    output logic             strobe,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int PAD = OW - DW;

    logic [DW-1:0] d_r;
    logic          sel_r;
    logic [DW-1:0] hold_i;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          emit;
    logic          err;
    logic          capture;
    logic [OW-1:0] word_i;
    logic [OW-1:0] word_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_r   <= '0;
            sel_r <= 1'b0;
        end else begin
            d_r   <= rx_d;
            sel_r <= rx_iqsel;
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        err       = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_HUNT: begin
                if (sel_r) begin
                    capture   = 1'b1;
                    state_nxt = ST_WANT_Q;
                end
            end
            ST_WANT_Q: begin
                if (!sel_r) begin
                    emit      = 1'b1;
                    state_nxt = ST_WANT_I;
                end else begin
                    err     = 1'b1;
                    capture = 1'b1;
                end
            end
            ST_WANT_I: begin
                if (sel_r) begin
                    capture   = 1'b1;
                    state_nxt = ST_WANT_Q;
                end else begin
                    err       = 1'b1;
                    state_nxt = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_HUNT;
            hold_i <= '0;
        end else begin
            state <= state_nxt;
            if (capture)
                hold_i <= d_r;
        end
    end

    assign word_i = {hold_i, {PAD{1'b0}}};
    assign word_q = {d_r, {PAD{1'b0}}};

`ifdef LMS_RX_TESTPAT_EN
    logic [OW-1:0] ramp;

    // The ramp only advances on strobes that actually carry the pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_i  <= '0;
            adc_q  <= '0;
            strobe <= 1'b0;
            ramp   <= '0;
        end else begin
            strobe <= emit;
            if (emit) begin
                if (test_mode) begin
                    adc_i <= ramp;
                    adc_q <= ~ramp;
                    ramp  <= ramp + OW'(4);
                end else begin
                    adc_i <= swap_iq ? word_q : word_i;
                    adc_q <= swap_iq ? word_i : word_q;
                end
            end
        end
    end
`else
    logic test_mode_unused;
    assign test_mode_unused = test_mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_i  <= '0;
            adc_q  <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= emit;
            if (emit) begin
                adc_i <= swap_iq ? word_q : word_i;
                adc_q <= swap_iq ? word_i : word_q;
            end
        end
    end
`endif

    lms_frame_mon #(
        .LOCK_PAIRS (LOCK_PAIRS),
        .ERR_W      (ERR_W)
    ) u_frame_mon (
        .clk     (clk),
        .reset_n (reset_n),
        .emit    (emit),
        .err     (err),
        .clr_err (clr_err),
        .locked  (locked),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_lms_rx_iq_deinterleave.sv
// Directed self-checking bench for lms_rx_iq_deinterleave; the ramp check
// is only built when LMS_RX_TESTPAT_EN is defined.
module tb_lms_rx_iq_deinterleave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rx_d = '0;
    logic        rx_iqsel = 1'b0;
    logic        swap_iq = 1'b0;
    logic        test_mode = 1'b0;
    logic        clr_err = 1'b0;
    logic [13:0] adc_i;
    logic [13:0] adc_q;
    logic        strobe;
    logic        locked;
    logic [15:0] err_cnt;

    int total = 0;
    int bad = 0;

    lms_rx_iq_deinterleave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_d      (rx_d),
        .rx_iqsel  (rx_iqsel),
        .swap_iq   (swap_iq),
        .test_mode (test_mode),
        .clr_err   (clr_err),
        .adc_i     (adc_i),
        .adc_q     (adc_q),
        .strobe    (strobe),
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // A word driven in one call is registered at the end of that call and
    // acted on by the FSM at the end of the next one.
    task automatic applyStimulus(input logic [11:0] d, input logic sel);
        rx_d     = d;
        rx_iqsel = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rx_d     = '0;
        rx_iqsel = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [13:0] exp_i;

        @(posedge clk);
        #1;
        checkOutput("rst_adc_i", 32'(adc_i), 32'h0);
        checkOutput("rst_adc_q", 32'(adc_q), 32'h0);
        checkOutput("rst_strobe", 32'(strobe), 32'h0);
        checkOutput("rst_locked", 32'(locked), 32'h0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'h0);
        reset_n = 1'b1;

        $display("[TB] clean stream");
        applyStimulus(12'h123, 1'b1);
        checkOutput("clean_no_strobe_i", 32'(strobe), 32'h0);
        applyStimulus(12'hABC, 1'b0);
        checkOutput("clean_no_strobe_q", 32'(strobe), 32'h0);
        applyStimulus(12'h123, 1'b1);
        checkOutput("clean_strobe1", 32'(strobe), 32'h1);
        checkOutput("clean_adc_i", 32'(adc_i), 32'h048C);
        checkOutput("clean_adc_q", 32'(adc_q), 32'h2AF0);
        checkOutput("clean_unlocked1", 32'(locked), 32'h0);
        applyStimulus(12'hABC, 1'b0);
        checkOutput("clean_gap", 32'(strobe), 32'h0);
        applyStimulus(12'h123, 1'b1);
        applyStimulus(12'hABC, 1'b0);
        applyStimulus(12'h123, 1'b1);
        checkOutput("clean_strobe3", 32'(strobe), 32'h1);
        checkOutput("clean_unlocked3", 32'(locked), 32'h0);
        applyStimulus(12'hABC, 1'b0);
        applyStimulus(12'h123, 1'b1);
        checkOutput("clean_strobe4", 32'(strobe), 32'h1);
        applyStimulus(12'hABC, 1'b0);
        checkOutput("clean_locked", 32'(locked), 32'h1);
        checkOutput("clean_err_cnt", 32'(err_cnt), 32'h0);

        $display("[TB] double I");
        applyStimulus(12'h111, 1'b1);
        applyStimulus(12'h222, 1'b1);
        applyStimulus(12'h333, 1'b0);
        checkOutput("dbl_i_err_cnt", 32'(err_cnt), 32'h1);
        checkOutput("dbl_i_unlocked", 32'(locked), 32'h0);
        applyStimulus(12'h123, 1'b1);
        checkOutput("dbl_i_strobe", 32'(strobe), 32'h1);
        checkOutput("dbl_i_adc_i", 32'(adc_i), 32'h0888);
        checkOutput("dbl_i_adc_q", 32'(adc_q), 32'h0CCC);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(12'hABC, 1'b0);
            applyStimulus(12'h123, 1'b1);
            checkOutput("relock_strobe", 32'(strobe), 32'h1);
            if (k == 1)
                checkOutput("relock_not_yet", 32'(locked), 32'h0);
        end
        applyStimulus(12'hABC, 1'b0);
        checkOutput("relock_locked", 32'(locked), 32'h1);

        $display("[TB] leading Q and double Q");
        doReset();
        applyStimulus(12'h555, 1'b0);
        applyStimulus(12'h555, 1'b0);
        checkOutput("lead_q_err", 32'(err_cnt), 32'h0);
        checkOutput("lead_q_strobe", 32'(strobe), 32'h0);
        applyStimulus(12'h0AA, 1'b1);
        applyStimulus(12'h055, 1'b0);
        applyStimulus(12'h066, 1'b0);
        checkOutput("dq_strobe", 32'(strobe), 32'h1);
        checkOutput("dq_adc_i", 32'(adc_i), 32'h02A8);
        checkOutput("dq_adc_q", 32'(adc_q), 32'h0154);
        applyStimulus(12'h077, 1'b0);
        checkOutput("dq_err_cnt", 32'(err_cnt), 32'h1);
        checkOutput("dq_no_strobe1", 32'(strobe), 32'h0);
        applyStimulus(12'h099, 1'b1);
        checkOutput("dq_no_strobe2", 32'(strobe), 32'h0);
        checkOutput("dq_hunt_silent", 32'(err_cnt), 32'h1);
        applyStimulus(12'h0BB, 1'b0);
        checkOutput("dq_no_strobe3", 32'(strobe), 32'h0);
        applyStimulus(12'h0BB, 1'b0);
        checkOutput("dq_resume_strobe", 32'(strobe), 32'h1);
        checkOutput("dq_resume_adc_i", 32'(adc_i), 32'h0264);
        checkOutput("dq_resume_adc_q", 32'(adc_q), 32'h02EC);

        $display("[TB] swap");
        doReset();
        swap_iq = 1'b1;
        applyStimulus(12'h001, 1'b1);
        applyStimulus(12'hFFF, 1'b0);
        applyStimulus(12'h001, 1'b1);
        checkOutput("swap_strobe", 32'(strobe), 32'h1);
        checkOutput("swap_adc_i", 32'(adc_i), 32'h3FFC);
        checkOutput("swap_adc_q", 32'(adc_q), 32'h0004);
        swap_iq = 1'b0;

        $display("[TB] error saturation");
        doReset();
        for (int k = 0; k < 65540; k++) begin
            applyStimulus(12'h001, 1'b1);
            if (k == 11)
                checkOutput("sat_partial", 32'(err_cnt), 32'd10);
        end
        checkOutput("sat_hold", 32'(err_cnt), 32'hFFFF);
        checkOutput("sat_unlocked", 32'(locked), 32'h0);
        clr_err = 1'b1;
        applyStimulus(12'h001, 1'b1);
        clr_err = 1'b0;
        checkOutput("clr_wins", 32'(err_cnt), 32'h0);
        applyStimulus(12'h001, 1'b1);
        checkOutput("count_after_clr", 32'(err_cnt), 32'h1);

        $display("[TB] reset mid-pair");
        doReset();
        applyStimulus(12'h123, 1'b1);
        applyStimulus(12'hABC, 1'b0);
        applyStimulus(12'h123, 1'b1);
        checkOutput("mid_pre_adc_i", 32'(adc_i), 32'h048C);
        applyStimulus(12'hABC, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_async_adc_i", 32'(adc_i), 32'h0);
        checkOutput("mid_async_adc_q", 32'(adc_q), 32'h0);
        checkOutput("mid_async_strobe", 32'(strobe), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(12'hABC, 1'b0);
            checkOutput("orphan_no_strobe", 32'(strobe), 32'h0);
        end
        checkOutput("orphan_no_err", 32'(err_cnt), 32'h0);

`ifdef LMS_RX_TESTPAT_EN
        $display("[TB] test pattern");
        doReset();
        test_mode = 1'b1;
        exp_i = 14'h0;
        applyStimulus(12'h123, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(12'hABC, 1'b0);
            applyStimulus(12'h123, 1'b1);
            checkOutput("pat_strobe", 32'(strobe), 32'h1);
            checkOutput("pat_adc_i", 32'(adc_i), 32'(exp_i));
            checkOutput("pat_adc_q", 32'(adc_q), 32'(14'(~exp_i)));
            exp_i = exp_i + 14'd4;
        end
        test_mode = 1'b0;
`else
        exp_i = 14'h0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
